// File: rtl/prefetch_queue.sv
// prefetch_queue
// Instruction prefetch buffer sitting between a combinational instruction ROM
// and the fetch stage. It owns the fetch PC and reads the ROM every cycle it
// has space. Each read is queued as a (pc, instr) pair in a small circular
// FIFO. The fetch stage drains the FIFO through a valid/ready handshake. A
// branch redirect flushes the queue and restarts prefetch at the target.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   rom_addr       ROM word address (the fetch PC, combinational)
//   rom_data       ROM read data for rom_addr, same cycle
//   redirect_valid branch taken, from execute
//   redirect_pc    branch target, from execute
//   out_valid      head entry valid
//   out_pc         PC of the head entry
//   out_instr      instruction of the head entry
//   out_ready      fetch stage accepts the head entry
//   level          number of occupied entries
module prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [15:0]              rom_addr,
  input  logic [15:0]              rom_data,
  input  logic                     redirect_valid,
  input  logic [15:0]              redirect_pc,
  output logic                     out_valid,
  output logic [15:0]              out_pc,
  output logic [15:0]              out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [15:0]   pc_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [LW-1:0] level_reg;

  logic [15:0]   pc_mem    [DEPTH];
  logic [15:0]   instr_mem [DEPTH];

  logic pop;
  logic push;

  // A redirect wins over everything: the head is not consumed and nothing is
  // written during the flush cycle.
  assign pop  = (level_reg != '0) & out_ready & ~redirect_valid;
  assign push = ~redirect_valid & ((level_reg < LW'(DEPTH)) | pop);

  assign rom_addr  = pc_reg;
  assign out_valid = (level_reg != '0);
  assign level     = level_reg;
  // Head is read straight from storage so a pop exposes the new head at once.
  assign out_pc    = pc_mem[rd_ptr_reg];
  assign out_instr = instr_mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg     <= PC_RESET;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (redirect_valid) begin
      pc_reg     <= redirect_pc;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        pc_reg     <= pc_reg + 16'd1;  // wraps FFFF -> 0000 naturally
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push && !pop) begin
        level_reg <= level_reg + LW'(1);
      end else if (pop && !push) begin
        level_reg <= level_reg - LW'(1);
      end
    end
  end

  // Storage entries are cleared on reset so the head reads as zero while the
  // queue has never been written.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pc_mem[gi]    <= 16'h0000;
          instr_mem[gi] <= 16'h0000;
        end else if (push && (wr_ptr_reg == AW'(gi))) begin
          pc_mem[gi]    <= pc_reg;
          instr_mem[gi] <= rom_data;
        end
      end
    end
  endgenerate

endmodule
